pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle fetch/execute controller that sequences the program counter of the highRISC core. It owns the fetch handshake and latches each instruction for the datapath. It then drives exactly one PC update strobe per instruction: increment, signed relative offset, or absolute load. Control-flow opcodes, halt, and an optional hardware return stack are decoded here.

## Interface
- RSTACK_DEPTH, 4: return-stack entries. Power of two, 2..16. Used only with PC_SEQ_CALLSTACK_EN.
- Clock  in  1  single clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; sampled on posedge Clock only.
- PcValue  in  16  current program-counter value.
- FetchReq  out  1  instruction fetch request, address = PcValue.
- FetchAck  in  1  memory returns FetchData this cycle.
- FetchData  in  16  instruction word.
- JumpTarget  in  16  register-file operand used by JMP/CALL.
- ExecDone  in  1  datapath has finished the current instruction.
- BranchTaken  in  1  branch condition; sampled only together with ExecDone.
- Instr  out  16  latched instruction.
- InstrValid  out  1  one-cycle pulse: Instr is new.
- PcIncEnable  out  1  PC += 1.
- PcOffsetEnable  out  1  PC += sign-extended PcOffset.
- PcOffset  out  9  two's-complement offset, Instr[8:0].
- PcLoadEnable  out  1  PC = PcLoadValue.
- PcLoadValue  out  16  absolute target.
- Halted  out  1  sequencer stopped.
- Fault  out  1  sticky error flag (stack over/underflow).

## Operation
- States: RST, FETCH, DECODE, EXEC, UPDATE, HALT.
- RST: entered while Reset is high. Always exits to FETCH on the first cycle after Reset falls.
- FETCH: FetchReq=1. On a cycle with FetchAck=1, capture FetchData into Instr and go to DECODE.
- DECODE: InstrValid=1 for exactly this cycle. Opcode = Instr[15:12]. Next state:
  - HALT if opcode = 4'hF.
  - EXEC otherwise.
- EXEC: wait for ExecDone=1. ExecDone may already be high on the first EXEC cycle. Capture BranchTaken in that cycle, then go to UPDATE.
- UPDATE: assert exactly one PC strobe for one cycle, then go to FETCH. The strobe is selected by opcode:
  - 4'hC BR: if captured BranchTaken, PcOffsetEnable with PcOffset = Instr[8:0]; else PcIncEnable. The offset is relative to the branch's own address.
  - 4'hD JMP: PcLoadEnable, PcLoadValue = JumpTarget (sampled in UPDATE).
  - 4'hE CALL/RET: handling depends on configuration; see below.
  - All other opcodes: PcIncEnable.
- HALT: no strobes, no FetchReq, Halted=1. Only Reset leaves HALT.
- Arithmetic: all PC arithmetic is modulo 2^16. PC 16'hFFFF plus increment gives 16'h0000. Return address = PcValue + 1, wrapped to 16 bits.
- The three PC strobes are mutually exclusive in every cycle.

## Timing
- Reset values of all outputs are 0: FetchReq, InstrValid, all strobes, PcOffset, PcLoadValue, Instr, Halted, Fault. The stack pointer is also cleared.
- Reset mid-operation: an outstanding fetch is abandoned, and a FetchAck arriving in the Reset cycle is ignored.
- Minimum instruction period is 4 cycles (FETCH, DECODE, EXEC, UPDATE), with FetchAck and ExecDone each arriving on the first cycle possible.
- FetchReq stays high until FetchAck; there is no timeout.
- PcValue is stable from DECODE through UPDATE and changes on the posedge that ends UPDATE.
- Fault and Halted are registered. Both rise on the posedge that ends the faulting UPDATE cycle, and both hold until Reset.

## Configuration
- Macro: PC_SEQ_CALLSTACK_EN.
- When defined:
  - CALL (4'hE, Instr[0]=0) pushes PcValue+1 and loads JumpTarget.
  - RET (4'hE, Instr[0]=1) pops the top entry onto PcLoadValue with PcLoadEnable.
  - Push when the stack is full, or pop when it is empty: no strobe, Fault=1, enter HALT.
- When not defined: opcode 4'hE is treated as an ordinary instruction (PcIncEnable), no stack storage is built, and Fault is tied to 0.

## Structure
- Package pc_seq_pkg holds:
  - state enum pc_seq_state_t;
  - opcode constants OP_BR, OP_JMP, OP_CALLRET, OP_HALT;
  - field positions for the opcode and offset.
- Sub-module pc_return_stack (only under the macro): LIFO, parameterised by RSTACK_DEPTH, with push/pop/full/empty, synchronous clear on Reset.

## Test plan
- Reset, then 3 ALU instructions at PC 0, with FetchAck and ExecDone immediate → 3 PcIncEnable pulses, each 4 cycles apart; PC ends at 3.
- BR at PC 16'h0010 with Instr[8:0]=9'h1F0 (−16):
  - BranchTaken=1 → PcOffsetEnable, PC becomes 16'h0000.
  - BranchTaken=0 → PcIncEnable, PC becomes 16'h0011.
- JMP with JumpTarget=16'hFFFF, followed by an ALU op → PC becomes 16'hFFFF, then wraps to 16'h0000.
- FetchAck delayed 5 cycles, with Reset asserted on cycle 3 → all outputs 0, late FetchAck ignored, FETCH re-entered one cycle after Reset falls.
- CALLSTACK_EN, depth 4: CALL at PC 16'h0100 to 16'h0200, then RET → PC becomes 16'h0200, then 16'h0101.
  - Five nested CALLs → Fault=1, Halted=1, no strobe on the fifth.
  - RET on an empty stack → same result.
- HALT opcode 16'hF000 → Halted=1 after DECODE, with no FetchReq or strobes for 20 cycles until Reset.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the highRISC PC sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5
    } pc_seq_state_t;

    localparam logic [3:0] OP_BR      = 4'hC;
    localparam logic [3:0] OP_JMP     = 4'hD;
    localparam logic [3:0] OP_CALLRET = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OFS_MSB = 8;
    localparam int unsigned OFS_LSB = 0;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO; only built when PC_SEQ_CALLSTACK_EN is defined.
`ifdef PC_SEQ_CALLSTACK_EN
module pc_return_stack #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_data,
    output logic [15:0] top_data,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [PW:0]   count;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] top_idx;

    assign wr_idx   = count[PW-1:0];
    assign top_idx  = count[PW-1:0] - PW'(1);
    // DEPTH is a power of two, so the count MSB alone marks a full stack.
    assign full     = count[PW];
    assign empty    = (count == '0);
    assign top_data = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + (PW+1)'(1);
        end else if (pop && !empty) begin
            count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !reset) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving one PC update strobe per instruction.
// Optional return stack for CALL/RET enabled by defining PC_SEQ_CALLSTACK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned RSTACK_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] PcValue,
    output logic        FetchReq,
    input  logic        FetchAck,
    input  logic [15:0] FetchData,
    input  logic [15:0] JumpTarget,
    input  logic        ExecDone,
    input  logic        BranchTaken,
    output logic [15:0] Instr,
    output logic        InstrValid,
    output logic        PcIncEnable,
    output logic        PcOffsetEnable,
    output logic [8:0]  PcOffset,
    output logic        PcLoadEnable,
    output logic [15:0] PcLoadValue,
    output logic        Halted,
    output logic        Fault
);

    pc_seq_state_t state, state_next;
    logic          branch_taken;
    logic [3:0]    opcode;

    assign opcode   = opcode_of(Instr);
    assign PcOffset = Instr[OFS_MSB:OFS_LSB];

`ifdef PC_SEQ_CALLSTACK_EN
    logic        stk_push, stk_pop, stk_full, stk_empty;
    logic [15:0] stk_top;
    logic [15:0] ret_addr;
    logic        fault_now;

    assign ret_addr = PcValue + 16'd1;

    pc_return_stack #(.DEPTH(RSTACK_DEPTH)) u_rstack (
        .clk       (Clock),
        .reset     (Reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (ret_addr),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{PcValue, 1'(RSTACK_DEPTH)};
`endif

    always_comb begin
        state_next     = state;
        FetchReq       = 1'b0;
        InstrValid     = 1'b0;
        PcIncEnable    = 1'b0;
        PcOffsetEnable = 1'b0;
        PcLoadEnable   = 1'b0;
        PcLoadValue    = '0;
`ifdef PC_SEQ_CALLSTACK_EN
        stk_push       = 1'b0;
        stk_pop        = 1'b0;
        fault_now      = 1'b0;
`endif
        case (state)
            ST_RST:    state_next = ST_FETCH;
            ST_FETCH: begin
                FetchReq = 1'b1;
                if (FetchAck) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                InstrValid = 1'b1;
                state_next = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (ExecDone) state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_next = ST_FETCH;
                case (opcode)
                    OP_BR: begin
                        if (branch_taken) PcOffsetEnable = 1'b1;
                        else              PcIncEnable    = 1'b1;
                    end
                    OP_JMP: begin
                        PcLoadEnable = 1'b1;
                        PcLoadValue  = JumpTarget;
                    end
`ifdef PC_SEQ_CALLSTACK_EN
                    OP_CALLRET: begin
                        // Over/underflow suppresses every strobe and stops the core.
                        if (!Instr[0]) begin
                            if (stk_full) begin
                                fault_now = 1'b1;
                            end else begin
                                stk_push     = 1'b1;
                                PcLoadEnable = 1'b1;
                                PcLoadValue  = JumpTarget;
                            end
                        end else begin
                            if (stk_empty) begin
                                fault_now = 1'b1;
                            end else begin
                                stk_pop      = 1'b1;
                                PcLoadEnable = 1'b1;
                                PcLoadValue  = stk_top;
                            end
                        end
                    end
`endif
                    default: PcIncEnable = 1'b1;
                endcase
`ifdef PC_SEQ_CALLSTACK_EN
                if (fault_now) state_next = ST_HALT;
`endif
            end
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_RST;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_RST;
            Instr        <= '0;
            branch_taken <= 1'b0;
            Halted       <= 1'b0;
        end else begin
            state  <= state_next;
            Halted <= (state_next == ST_HALT);
            if (state == ST_FETCH && FetchAck) Instr <= FetchData;
            if (state == ST_EXEC && ExecDone) branch_taken <= BranchTaken;
        end
    end

`ifdef PC_SEQ_CALLSTACK_EN
    always_ff @(posedge Clock) begin
        if (Reset)          Fault <= 1'b0;
        else if (fault_now) Fault <= 1'b1;
    end
`else
    assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; stack tests run when PC_SEQ_CALLSTACK_EN is defined.
module tb_pc_sequencer;

    typedef enum int {E_INC = 0, E_OFS = 1, E_LOAD = 2, E_HALT = 3} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] value;
        int          gap;
    } exp_t;

    logic        Clock;
    logic        Reset = 1'b1;
    logic [15:0] PcValue;
    logic        FetchReq;
    logic        FetchAck;
    logic [15:0] FetchData;
    logic [15:0] JumpTarget = '0;
    logic        ExecDone;
    logic        BranchTaken;
    logic [15:0] Instr;
    logic        InstrValid;
    logic        PcIncEnable;
    logic        PcOffsetEnable;
    logic [8:0]  PcOffset;
    logic        PcLoadEnable;
    logic [15:0] PcLoadValue;
    logic        Halted;
    logic        Fault;

    pc_sequencer #(.RSTACK_DEPTH(4)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .PcValue        (PcValue),
        .FetchReq       (FetchReq),
        .FetchAck       (FetchAck),
        .FetchData      (FetchData),
        .JumpTarget     (JumpTarget),
        .ExecDone       (ExecDone),
        .BranchTaken    (BranchTaken),
        .Instr          (Instr),
        .InstrValid     (InstrValid),
        .PcIncEnable    (PcIncEnable),
        .PcOffsetEnable (PcOffsetEnable),
        .PcOffset       (PcOffset),
        .PcLoadEnable   (PcLoadEnable),
        .PcLoadValue    (PcLoadValue),
        .Halted         (Halted),
        .Fault          (Fault)
    );

    logic [15:0] imem [0:65535];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          ack_delay = 0;
    logic        br_val = 1'b0;
    logic        load_pc_req = 1'b0;
    logic [15:0] load_pc_val = '0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [15:0] v, input int gap);
        exp_t e;
        e.kind  = k;
        e.value = v;
        e.gap   = gap;
        sb.push_back(e);
    endtask

    // Environment: PC register, fetch memory and execute unit.
    initial begin : env
        logic [15:0] pc_n;
        int          ack_wait;
        logic        exec_next;
        ack_wait = 0;
        exec_next = 1'b0;
        PcValue = '0; FetchAck = 1'b0; FetchData = '0; ExecDone = 1'b0; BranchTaken = 1'b0;
        forever begin
            @(negedge Clock);
            pc_n = PcValue;
            if (PcIncEnable)         pc_n = PcValue + 16'd1;
            else if (PcOffsetEnable) pc_n = PcValue + {{7{PcOffset[8]}}, PcOffset};
            else if (PcLoadEnable)   pc_n = PcLoadValue;
            @(posedge Clock);
            #1;
            cycle++;
            if (load_pc_req) begin
                PcValue = load_pc_val;
                load_pc_req = 1'b0;
            end else begin
                PcValue = pc_n;
            end
            FetchAck = 1'b0;
            if (FetchReq) begin
                if (ack_wait >= ack_delay) begin
                    FetchAck  = 1'b1;
                    FetchData = imem[PcValue];
                    ack_wait  = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
            ExecDone = 1'b0;
            BranchTaken = 1'b0;
            if (exec_next) begin
                ExecDone = 1'b1;
                BranchTaken = br_val;
            end
            exec_next = InstrValid;
        end
    end

    initial begin : monitor
        int          nstb;
        int          last_strobe;
        logic        prev_halted;
        ev_kind_t    kind;
        logic [15:0] result;
        exp_t        e;
        last_strobe = 0;
        prev_halted = 1'b0;
        forever begin
            @(negedge Clock);
            nstb = int'(PcIncEnable) + int'(PcOffsetEnable) + int'(PcLoadEnable);
            if (nstb != 0) begin
                check_eq("strobe_onehot", 32'(nstb), 32'd1);
                if (PcIncEnable) begin
                    kind = E_INC;  result = PcValue + 16'd1;
                end else if (PcOffsetEnable) begin
                    kind = E_OFS;  result = PcValue + {{7{PcOffset[8]}}, PcOffset};
                end else begin
                    kind = E_LOAD; result = PcLoadValue;
                end
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got kind %0d, want none (t=%0t)", kind, $time);
                end else begin
                    e = sb.pop_front();
                    check_eq("strobe_kind", 32'(kind), 32'(e.kind));
                    check_eq("pc_result", 32'(result), 32'(e.value));
                    if (e.gap != 0) check_eq("strobe_gap", 32'(cycle - last_strobe), 32'(e.gap));
                end
                last_strobe = cycle;
            end
            if (Halted && !prev_halted) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_halt: got Halted=1, want 0 (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check_eq("halt_kind", 32'(E_HALT), 32'(e.kind));
                    check_eq("halt_fault", 32'(Fault), 32'(e.value[0]));
                end
            end
            prev_halted = Halted;
        end
    end

    task automatic check_reset_outputs();
        check_eq("reset_flags",
                 32'({FetchReq, InstrValid, PcIncEnable, PcOffsetEnable, PcLoadEnable, Halted, Fault, PcOffset}),
                 32'd0);
        check_eq("reset_words", {PcLoadValue, Instr}, 32'd0);
    endtask

    task automatic do_reset(input logic [15:0] start);
        @(negedge Clock);
        Reset = 1'b1;
        load_pc_req = 1'b1;
        load_pc_val = start;
        @(negedge Clock);
        check_reset_outputs();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d pending events, want 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge Clock);
    endtask

    initial begin : stimulus
        logic bad;
        for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;

        // Three ALU ops from PC 0 at minimum period
        imem[16'h0000] = 16'h0000; imem[16'h0001] = 16'h1234; imem[16'h0002] = 16'h2001;
        imem[16'h0003] = 16'hF000;
        ack_delay = 0; br_val = 1'b0;
        expect_ev(E_INC, 16'h0001, 0);
        expect_ev(E_INC, 16'h0002, 4);
        expect_ev(E_INC, 16'h0003, 4);
        expect_ev(E_HALT, 16'h0000, 0);
        do_reset(16'h0000);
        wait_drain("alu");
        check_eq("pc_end_alu", 32'(PcValue), 32'h0003);

        // Branch taken, offset -16
        imem[16'h0010] = 16'hC1F0; imem[16'h0000] = 16'hF000; imem[16'h0011] = 16'hF000;
        br_val = 1'b1;
        expect_ev(E_OFS, 16'h0000, 0);
        expect_ev(E_HALT, 16'h0000, 0);
        do_reset(16'h0010);
        wait_drain("br_taken");

        // Branch not taken
        br_val = 1'b0;
        expect_ev(E_INC, 16'h0011, 0);
        expect_ev(E_HALT, 16'h0000, 0);
        do_reset(16'h0010);
        wait_drain("br_not_taken");

        // JMP to FFFF then wrap
        imem[16'h0020] = 16'hD000; imem[16'hFFFF] = 16'h1234;
        JumpTarget = 16'hFFFF;
        expect_ev(E_LOAD, 16'hFFFF, 0);
        expect_ev(E_INC, 16'h0000, 4);
        expect_ev(E_HALT, 16'h0000, 0);
        do_reset(16'h0020);
        wait_drain("jmp_wrap");

        // Reset lands in the same cycle as a late FetchAck
        imem[16'h0040] = 16'hF000; imem[16'h0050] = 16'h0ABC; imem[16'h0051] = 16'hF000;
        ack_delay = 2;
        do_reset(16'h0040);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        load_pc_req = 1'b1;
        load_pc_val = 16'h0050;
        ack_delay = 5;
        expect_ev(E_INC, 16'h0051, 0);
        expect_ev(E_HALT, 16'h0000, 0);
        @(negedge Clock);
        check_reset_outputs();
        @(negedge Clock);
        check_eq("fetchreq_in_rst", 32'(FetchReq), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check_eq("fetchreq_after_rst", 32'(FetchReq), 32'd1);
        wait_drain("reset_mid_fetch");
        ack_delay = 0;

`ifdef PC_SEQ_CALLSTACK_EN
        // CALL then RET
        imem[16'h0100] = 16'hE000; imem[16'h0200] = 16'hE001; imem[16'h0101] = 16'hF000;
        JumpTarget = 16'h0200;
        expect_ev(E_LOAD, 16'h0200, 0);
        expect_ev(E_LOAD, 16'h0101, 4);
        expect_ev(E_HALT, 16'h0000, 0);
        do_reset(16'h0100);
        wait_drain("call_ret");

        // Five nested CALLs overflow a 4-deep stack
        imem[16'h0300] = 16'hE000;
        JumpTarget = 16'h0300;
        for (int i = 0; i < 4; i++) expect_ev(E_LOAD, 16'h0300, 0);
        expect_ev(E_HALT, 16'h0001, 0);
        do_reset(16'h0300);
        wait_drain("call_overflow");
        check_eq("overflow_halted", 32'({Halted, Fault}), 32'b11);

        // RET on empty stack (also proves reset cleared the pointer)
        imem[16'h0400] = 16'hE001;
        expect_ev(E_HALT, 16'h0001, 0);
        do_reset(16'h0400);
        wait_drain("ret_underflow");
        check_eq("underflow_halted", 32'({Halted, Fault}), 32'b11);
`else
        // Without the stack, CALL/RET opcodes simply advance the PC
        imem[16'h0060] = 16'hE000; imem[16'h0061] = 16'hE001; imem[16'h0062] = 16'hF000;
        JumpTarget = 16'h0200;
        expect_ev(E_INC, 16'h0061, 0);
        expect_ev(E_INC, 16'h0062, 4);
        expect_ev(E_HALT, 16'h0000, 0);
        do_reset(16'h0060);
        wait_drain("callret_plain");
        check_eq("fault_tied_low", 32'(Fault), 32'd0);
`endif

        // HALT opcode stays quiet until reset
        imem[16'h0500] = 16'hF000;
        expect_ev(E_HALT, 16'h0000, 0);
        do_reset(16'h0500);
        wait_drain("halt");
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (FetchReq || PcIncEnable || PcOffsetEnable || PcLoadEnable || InstrValid || !Halted)
                bad = 1'b1;
        end
        check_eq("halt_quiet", 32'(bad), 32'd0);
        check_eq("halt_pc", 32'(PcValue), 32'h0500);
        do_reset(16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
